prog_updown_counter: RTL
========================

# prog_updown_counter

Parametrised up/down counter with programmable modulus, step size, and three count modes: wrap, saturate, and one-shot. It is the general-purpose successor to the plain load/up/down counter. It is used wherever the design needs timers, modulo-N sequencers or bounded position counters. It adds enable, synchronous clear, registered overflow/underflow pulses and a one-shot run FSM with busy/done status.

## Interface
- N, 8, counter width in bits (≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clock clk
- en  input  1  count enable; when low, count holds (clear/load/start still act)
- clear  input  1  synchronous clear to 0; FSM returns to IDLE
- load  input  1  synchronous load of load_data
- load_data  input  N  value loaded on load
- up_down  input  1  1 = count up, 0 = count down
- step  input  N  increment/decrement magnitude; 0 = hold
- limit  input  N  upper bound; valid range is 0..limit
- mode  input  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved (behaves as SAT)
- start  input  1  one-shot arm/start (ONESHOT only)
- count  output  N  registered count
- ovf  output  1  registered one-cycle pulse: up step passed limit (WRAP/SAT)
- unf  output  1  registered one-cycle pulse: down step passed 0 (WRAP/SAT)
- tc  output  1  combinational terminal count: (up_down & count==limit) | (~up_down & count==0)
- busy  output  1  FSM in RUN
- done  output  1  FSM in DONE

## Operation
- Priority each edge: reset > clear > load > start > enabled count.
- Up step:
  - The boundary is crossed when count+step > limit, evaluated in N+1 bits. This includes the case where count > limit after a load.
- Down step:
  - The boundary is crossed when step > count.
- WRAP:
  - On an up crossing, count ← 0 and ovf pulses.
  - On a down crossing, count ← limit and unf pulses.
  - Otherwise count ± step.
- SAT:
  - On an up crossing, count ← limit and ovf pulses.
  - On a down crossing, count ← 0 and unf pulses.
  - The pulse repeats on every enabled cycle the step is still attempted.
- ONESHOT FSM, states IDLE / RUN / DONE:
  - IDLE: count holds and en is ignored. start moves to RUN and loads count ← 0 (up) or limit (down).
  - RUN: counts on en. When the next value reaches or crosses the boundary, count ← boundary and the FSM moves to DONE on the same edge.
  - DONE: count holds. start re-arms (→ RUN, with the reload as in IDLE). clear → IDLE.
- ovf and unf never pulse in ONESHOT.
- load in RUN updates count and the FSM stays in RUN. load in IDLE or DONE updates count only.
- mode ≠ ONESHOT forces the FSM to IDLE on the next edge, so busy and done drop.
- step=0 holds count with no boundary event, except when count+0 > limit in the up direction. That case counts as a crossing.
- ovf and unf are cleared on any cycle without a crossing, including clear, load and en=0 cycles.

## Timing
- Reset values: count=0, ovf=0, unf=0, busy=0, done=0, FSM=IDLE. tc reflects count=0 combinationally.
- All updates take one cycle: an input sampled at edge k is reflected in count/ovf/unf/busy/done after edge k.
- ovf/unf are aligned with the edge that applies the wrapped/clamped count.
- tc has zero latency from count, limit and up_down.
- Reset mid-RUN aborts immediately. No done pulse is produced.

## Structure
- Package prog_counter_pkg holds:
  - typedef for mode_t (MODE_WRAP, MODE_SAT, MODE_ONESHOT)
  - typedef for os_state_t (OS_IDLE, OS_RUN, OS_DONE)
- Sub-module prog_counter_next: purely combinational. It takes count, step, limit, up_down and mode. It returns next_count, cross_up, cross_dn and reach (reach = next value equals or crosses the boundary).
- The top level holds the count register, the pulse registers and the ONESHOT FSM.

## Test plan
- WRAP, limit=9, step=1, up, count=8, en=1: count 9, then 0 with ovf=1 for exactly one cycle; tc=1 while count=9.
- WRAP, limit=9, step=3, up from 7: next count=0 with ovf pulse. Then down from 1 with step=3: count=9 with unf pulse.
- SAT, down, step=3, from 2: count=0 with unf=1. Holding en=1 keeps count=0 and unf=1 every cycle; en=0 drops unf.
- ONESHOT, up, limit=4, step=1, start then en=1: count 0,1,2,3,4. done=1 and busy=0 on the edge count becomes 4; count stays 4; ovf stays 0. A second start gives count=0 and busy=1.
- Priority: clear=1 and load=1 with load_data=0x55 in the same cycle gives count=0. Load 0xF0 with limit=9 in WRAP, then one up step gives count=0 and ovf=1.
- Reset asserted asynchronously mid-RUN at count=2: all outputs read their reset values before the next clk edge; FSM is in IDLE.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable up/down counter: count modes and
// the one-shot run FSM states.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    OS_IDLE = 2'd0,
    OS_RUN  = 2'd1,
    OS_DONE = 2'd2
  } os_state_t;

endpackage

// File: rtl/prog_counter_next.sv
// Combinational next-count datapath: boundary detection and the
// wrapped / clamped / one-shot next value for a single step.
module prog_counter_next
  import prog_counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] i_count,
  input  logic [N-1:0] i_step,
  input  logic [N-1:0] i_limit,
  input  logic         i_up_down,
  input  logic [1:0]   i_mode,
  output logic [N-1:0] o_next_count,
  output logic         o_cross_up,
  output logic         o_cross_dn,
  output logic         o_reach
);

  logic [N:0]   w_sum;
  logic [N-1:0] w_diff;
  logic [N-1:0] w_plain;
  mode_t        w_mode;

  // One extra bit so count+step can never alias below the limit.
  assign w_sum  = {1'b0, i_count} + {1'b0, i_step};
  assign w_diff = i_count - i_step;
  assign w_mode = mode_t'(i_mode);

  always_comb begin
    o_cross_up   = i_up_down && (w_sum > {1'b0, i_limit});
    o_cross_dn   = !i_up_down && (i_step > i_count);
    o_reach      = i_up_down ? (w_sum >= {1'b0, i_limit}) : (i_step >= i_count);
    w_plain      = i_up_down ? w_sum[N-1:0] : w_diff;
    o_next_count = w_plain;
    case (w_mode)
      MODE_WRAP: begin
        if (o_cross_up)      o_next_count = '0;
        else if (o_cross_dn) o_next_count = i_limit;
      end
      MODE_ONESHOT: begin
        if (o_reach) o_next_count = i_up_down ? i_limit : '0;
      end
      // SAT and the reserved encoding share the clamping behaviour.
      default: begin
        if (o_cross_up)      o_next_count = i_limit;
        else if (o_cross_dn) o_next_count = '0;
      end
    endcase
  end

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with WRAP / SAT / ONESHOT modes, registered
// overflow/underflow pulses and a one-shot run FSM exposing busy/done.
module prog_updown_counter
  import prog_counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [N-1:0] i_load_data,
  input  logic         i_up_down,
  input  logic [N-1:0] i_step,
  input  logic [N-1:0] i_limit,
  input  logic [1:0]   i_mode,
  input  logic         i_start,
  output logic [N-1:0] o_count,
  output logic         o_ovf,
  output logic         o_unf,
  output logic         o_tc,
  output logic         o_busy,
  output logic         o_done
);

  logic [N-1:0] r_count;
  logic         r_ovf;
  logic         r_unf;
  os_state_t    r_state;

  logic [N-1:0] w_count_next;
  logic         w_ovf_next;
  logic         w_unf_next;
  os_state_t    w_state_next;

  logic [N-1:0] w_step_count;
  logic         w_cross_up;
  logic         w_cross_dn;
  logic         w_reach;
  logic         w_is_oneshot;
  logic [N-1:0] w_reload;

  prog_counter_next #(.N(N)) u_next (
    .i_count      (r_count),
    .i_step       (i_step),
    .i_limit      (i_limit),
    .i_up_down    (i_up_down),
    .i_mode       (i_mode),
    .o_next_count (w_step_count),
    .o_cross_up   (w_cross_up),
    .o_cross_dn   (w_cross_dn),
    .o_reach      (w_reach)
  );

  assign w_is_oneshot = (i_mode == MODE_ONESHOT);
  assign w_reload     = i_up_down ? '0 : i_limit;

  // Edge priority: clear > load > start > enabled count.
  always_comb begin
    w_count_next = r_count;
    w_state_next = r_state;
    w_ovf_next   = 1'b0;
    w_unf_next   = 1'b0;
    if (i_clear) begin
      w_count_next = '0;
      w_state_next = OS_IDLE;
    end else if (i_load) begin
      w_count_next = i_load_data;
      if (!w_is_oneshot) w_state_next = OS_IDLE;
    end else if (w_is_oneshot && i_start) begin
      w_count_next = w_reload;
      w_state_next = OS_RUN;
    end else if (!w_is_oneshot) begin
      w_state_next = OS_IDLE;
      if (i_en) begin
        w_count_next = w_step_count;
        w_ovf_next   = w_cross_up;
        w_unf_next   = w_cross_dn;
      end
    end else if (r_state == OS_RUN && i_en) begin
      w_count_next = w_step_count;
      if (w_reach) w_state_next = OS_DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_state <= OS_IDLE;
    end else begin
      r_count <= w_count_next;
      r_ovf   <= w_ovf_next;
      r_unf   <= w_unf_next;
      r_state <= w_state_next;
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;
  assign o_busy  = (r_state == OS_RUN);
  assign o_done  = (r_state == OS_DONE);
  assign o_tc    = (i_up_down && (r_count == i_limit)) || (!i_up_down && (r_count == '0));

endmodule
